seq_entry: RTL and testbench
============================

# seq_entry

Captures a user-entered 4-digit sequence (4 bits per digit) from the board switches, one digit per debounced key press, and hands the completed 16-bit sequence downstream with a valid/ready handshake. It sits between the raw board I/O (`KEY`, `SW`) and the sequence comparison/display stage inside `topo`, which consumes `seq_out` and drives `LEDR`/`HEX*`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000, is the number of consecutive stable cycles (20 ms at 50 MHz) before a key level is accepted; legal range is ≥ 2.
- `DIGITS`, default 4, is the number of digits per sequence; fixed at 4 for this revision.
- `DW`, default 4, is the digit width in bits.

Ports (one clock; reset is synchronous and active-high):
- `CLOCK_50  in  1`: the only clock; all logic is on its rising edge.
- `reset  in  1`: synchronous, active-high; driven from `SW[1]` at top level.
- `key_n  in  1`: raw `KEY[0]`, active-low, asynchronous. Each press enters one digit.
- `key_clr_n  in  1`: raw `KEY[1]`, active-low, asynchronous. Discards a partial entry.
- `digit_in  in  4`: `SW[3:0]`, the digit value; treated as quasi-static.
- `seq_ready  in  1`: asserted by the downstream stage when it can accept a sequence.
- `seq_valid  out  1`: high while a complete sequence is held.
- `seq_out  out  16`: the captured sequence. The first digit is in `[15:12]` and the last in `[3:0]`.
- `digit_count  out  3`: the number of digits captured, from 0 to 4.

## Operation
**Key conditioning**
- Each raw key passes through a 2-FF synchronizer preset to 1 and then a debouncer.
- The debouncer's `stable` output, reset value 1, flips only after the synchronized level has differed from `stable` for `DEBOUNCE_CYCLES` consecutive cycles.
- Any return to the `stable` level clears the counter.
- A press event is a one-cycle pulse on the `stable` 1→0 transition. Releases generate no event.

**FSM**
- `COLLECT`, the reset state:
  - On a press event with `digit_count < 4`, `seq_out` is shifted left by 4 with `digit_in` inserted, and `digit_count` increments.
  - When this press makes `digit_count` reach 4, the FSM goes to `FULL`.
  - On a clear event, `seq_out` and `digit_count` go to 0 and the FSM stays in `COLLECT`.
- `FULL`:
  - `seq_valid` is 1.
  - Press and clear events are ignored; `seq_out` and `digit_count` are held.
  - When `seq_valid & seq_ready` at an edge, the FSM returns to `COLLECT` next cycle with `seq_out = 0`, `digit_count = 0`, and `seq_valid = 0`.

**Boundaries**
- Press and clear on the same edge in `COLLECT`: clear wins and no digit is captured.
- A press event on the handshake edge is dropped.
- `seq_ready` high while in `COLLECT` has no effect.
- `reset` mid-entry or mid-handshake aborts immediately. There is no partial state retention and no `seq_valid` glitch.
- A key held down produces exactly one press event.

## Timing
**Reset values:**
- `seq_valid = 0`, `seq_out = 16'h0000`, `digit_count = 0`, state `COLLECT`.
- Synchronizers and debouncer `stable` are 1; debounce counters are 0.

**Latencies:**
- Let edge N be the first edge that samples the raw key low, with the key held low afterwards.
- The press event is high in the cycle after edge N+1+`DEBOUNCE_CYCLES`.
- `digit_in` is sampled at the next edge. `seq_out` and `digit_count` update after that edge.

**Fourth digit:** `seq_valid` rises in the same cycle that `digit_count` becomes 4.

**Handshake:**
- Transfer occurs at the first edge where `seq_valid & seq_ready`.
- `seq_out` is stable from the `seq_valid` rise through the transfer edge.
- `seq_valid` drops the cycle after the transfer.
- Minimum interval between sequences is bounded only by debounce.

## Structure
- Shared package `seq_pkg` holds:
  - the state encoding (`ST_COLLECT = 1'b0`, `ST_FULL = 1'b1`);
  - `DIGIT_W = 4`, `SEQ_DIGITS = 4`, and `SEQ_W = 16`.
- One sub-module, `key_debounce`, covers the synchronizer, counter, `stable` register and falling-edge pulse. It takes parameter `DEBOUNCE_CYCLES` and ports `CLOCK_50`, `reset`, `key_n`, `press`. `seq_entry` instantiates it twice.
- The counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4` and hold `seq_ready = 0` unless stated.
- **Digit entry:** enter digits 3, A, 5, C with clean presses → `seq_out = 16'h3A5C`, `digit_count = 4`, `seq_valid = 1`, and the 4th digit's event appears the cycle after edge N+5.
- **Bounce and hold:** a key bounce of 1-2 cycles low, then high → no event and `digit_count` unchanged. A key held for 50 cycles → exactly one digit captured.
- **Clear:** after 2 digits (`16'h0012`), press clear → `seq_out = 0`, `digit_count = 0`. Press and clear recognised on the same edge → clear wins and `digit_count = 0`.
- **Hold in `FULL`:** with `16'h3A5C` held, extra presses and clears are ignored for 20 cycles. Raise `seq_ready` → `seq_valid` drops one cycle later and `seq_out = 0`.
- **Reset mid-entry:** assert `reset` for 1 cycle after 3 digits, and separately while `seq_valid = 1` → all outputs return to their reset values on the next edge, and a fresh 4-digit entry then completes normally.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-entry block: FSM state encoding,
// sequence geometry and the digit shift helper.
package seq_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } seq_state_t;

    localparam int DIGIT_W    = 4;
    localparam int SEQ_DIGITS = 4;
    localparam int SEQ_W      = DIGIT_W * SEQ_DIGITS;

    // Shift the sequence one digit to the left and append the new digit, so
    // the first digit entered ends up in the most significant position.
    function automatic logic [SEQ_W-1:0] shift_digit(
        input logic [SEQ_W-1:0]   seq,
        input logic [DIGIT_W-1:0] digit
    );
        return {seq[SEQ_W-DIGIT_W-1:0], digit};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Conditions one raw active-low push button: 2-FF synchronizer, a
// consecutive-cycle debouncer and a one-cycle press pulse on the debounced
// high-to-low transition. Releases produce no pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;
    logic             differ_s;
    logic             expire_s;

    // Detect a level that disagrees with the accepted one and whether this
    // is the last disagreeing cycle needed before it is accepted.
    always_comb begin
        differ_s = (sync2_r != stable_r);
        expire_s = differ_s && (cnt_r == CNT_LAST);
    end

    // Two-stage synchronizer, preset to the released (high) level.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    // Debounce counter, accepted level and press pulse; any cycle that
    // matches the accepted level restarts the count.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= 1'b1;
            press_r  <= 1'b0;
        end else if (expire_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= sync2_r;
            press_r  <= ~sync2_r;
        end else if (differ_s) begin
            cnt_r    <= cnt_r + CNT_W'(1);
            press_r  <= 1'b0;
        end else begin
            cnt_r    <= {CNT_W{1'b0}};
            press_r  <= 1'b0;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/seq_entry.sv
// Captures a 4-digit sequence from the switches, one digit per debounced
// key press, and offers it downstream through a valid/ready handshake.
// A second key discards a partial entry.
module seq_entry
    import seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DIGITS          = 4,
    parameter int DW              = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 key_n,
    input  logic                 key_clr_n,
    input  logic [DW-1:0]        digit_in,
    input  logic                 seq_ready,
    output logic                 seq_valid,
    output logic [DIGITS*DW-1:0] seq_out,
    output logic [2:0]           digit_count
);

    localparam logic [2:0] CNT_FULL = 3'(SEQ_DIGITS);
    localparam logic [2:0] CNT_LAST = 3'(SEQ_DIGITS - 1);

    seq_state_t       state_r;
    logic [SEQ_W-1:0] seq_out_r;
    logic [2:0]       digit_count_r;
    logic             seq_valid_r;
    logic             press_s;
    logic             clr_s;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_digit (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_n    (key_n),
        .press    (press_s)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_clear (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_n    (key_clr_n),
        .press    (clr_s)
    );

    // Entry FSM with registered outputs: collect digits, then hold the full
    // sequence until the downstream stage takes it.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r       <= ST_COLLECT;
            seq_out_r     <= {SEQ_W{1'b0}};
            digit_count_r <= 3'd0;
            seq_valid_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_COLLECT: begin
                    if (clr_s) begin
                        // Clear has priority over a press on the same edge.
                        seq_out_r     <= {SEQ_W{1'b0}};
                        digit_count_r <= 3'd0;
                    end else if (press_s && (digit_count_r < CNT_FULL)) begin
                        seq_out_r     <= shift_digit(seq_out_r, digit_in);
                        digit_count_r <= digit_count_r + 3'd1;
                        if (digit_count_r == CNT_LAST) begin
                            state_r     <= ST_FULL;
                            seq_valid_r <= 1'b1;
                        end else begin
                            state_r     <= ST_COLLECT;
                        end
                    end else begin
                        state_r <= ST_COLLECT;
                    end
                end
                ST_FULL: begin
                    // Key events are ignored here; a press on the
                    // handshake edge is dropped as well.
                    if (seq_valid_r && seq_ready) begin
                        state_r       <= ST_COLLECT;
                        seq_out_r     <= {SEQ_W{1'b0}};
                        digit_count_r <= 3'd0;
                        seq_valid_r   <= 1'b0;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    state_r       <= ST_COLLECT;
                    seq_out_r     <= {SEQ_W{1'b0}};
                    digit_count_r <= 3'd0;
                    seq_valid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign seq_valid   = seq_valid_r;
    assign seq_out     = seq_out_r;
    assign digit_count = digit_count_r;

endmodule

// File: tb/tb_seq_entry.sv
// Self-checking bench for seq_entry with a short debounce window. Key
// activity is generated as low runs of chosen length; a reference model
// turns each run into digit/clear events from the debounce rules and
// predicts the outputs on every cycle.
module tb_seq_entry;

    localparam int D = 4;

    logic        CLOCK_50;
    logic        reset;
    logic        key_n;
    logic        key_clr_n;
    logic [3:0]  digit_in;
    logic        seq_ready;
    logic        seq_valid;
    logic [15:0] seq_out;
    logic [2:0]  digit_count;

    int total_r;
    int bad_r;

    // Reference model state
    int m_seq;
    int m_cnt;
    bit m_valid;

    seq_entry #(
        .DEBOUNCE_CYCLES (D),
        .DIGITS          (4),
        .DW              (4)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .key_n       (key_n),
        .key_clr_n   (key_clr_n),
        .digit_in    (digit_in),
        .seq_ready   (seq_ready),
        .seq_valid   (seq_valid),
        .seq_out     (seq_out),
        .digit_count (digit_count)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_r++;
        if (got !== exp) begin
            bad_r++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word();
        return {11'd0, m_valid, m_cnt[3:0], m_seq[15:0]};
    endfunction

    function automatic logic [31:0] dut_word();
        return {11'd0, seq_valid, 1'b0, digit_count, seq_out};
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Model: a digit press is accepted only while collecting and not full.
    task automatic model_events(input bit pe, input bit ce, input int d);
        if (!m_valid) begin
            if (ce) begin
                m_seq = 0;
                m_cnt = 0;
            end else if (pe && m_cnt < 4) begin
                m_seq = ((m_seq * 16) + d) % 65536;
                m_cnt = m_cnt + 1;
                if (m_cnt == 4) m_valid = 1'b1;
            end
        end
    endtask

    // Hold one or both keys low for len cycles, then release and let the
    // debouncers settle. A run of at least D low samples is one event, which
    // reaches the outputs at the edge D+2 after the first low sample.
    task automatic key_run(input string tag, input int len, input bit use_key,
                           input bit use_clr, input logic [3:0] d, input bit rdy);
        logic [31:0] pre_w;
        bit          pe;
        bit          ce;
        int          span;
        pre_w      = model_word();
        digit_in   = d;
        seq_ready  = rdy;
        pe         = use_key && (len >= D);
        ce         = use_clr && (len >= D);
        if (use_key) key_n = 1'b0;
        if (use_clr) key_clr_n = 1'b0;
        span = ((len > D + 3) ? len : D + 3) + D + 6;
        for (int t = 1; t <= span; t++) begin
            tick();
            if (t == len) begin
                key_n     = 1'b1;
                key_clr_n = 1'b1;
            end
            if (t == D + 3) model_events(pe, ce, int'(d));
            if (t < D + 3) chk_val({tag, "_pre"}, dut_word(), pre_w);
            else           chk_val({tag, "_post"}, dut_word(), model_word());
        end
        seq_ready = 1'b0;
    endtask

    task automatic handshake(input string tag);
        chk_val({tag, "_valid_before"}, {31'd0, seq_valid}, {31'd0, m_valid});
        seq_ready = 1'b1;
        tick();
        if (m_valid) begin
            m_valid = 1'b0;
            m_seq   = 0;
            m_cnt   = 0;
        end
        chk_val({tag, "_after"}, dut_word(), model_word());
        seq_ready = 1'b0;
        tick();
        chk_val({tag, "_idle"}, dut_word(), model_word());
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        tick();
        m_valid = 1'b0;
        m_seq   = 0;
        m_cnt   = 0;
        chk_val({tag, "_in"}, dut_word(), 32'd0);
        reset = 1'b0;
        tick();
        chk_val({tag, "_out"}, dut_word(), model_word());
    endtask

    task automatic enter_four(input string tag, input logic [15:0] s);
        logic [15:0] v;
        v = s;
        for (int i = 3; i >= 0; i--) begin
            key_run(tag, D + 3 + int'($urandom_range(0, 6)), 1'b1, 1'b0,
                    v[i*4 +: 4], 1'b0);
        end
    endtask

    initial begin
        logic [15:0] s;
        int          op;
        total_r   = 0;
        bad_r     = 0;
        m_seq     = 0;
        m_cnt     = 0;
        m_valid   = 1'b0;
        reset     = 1'b1;
        key_n     = 1'b1;
        key_clr_n = 1'b1;
        digit_in  = 4'h0;
        seq_ready = 1'b0;
        tick();
        tick();
        chk_val("reset_state", dut_word(), 32'd0);
        reset = 1'b0;
        tick();
        chk_val("after_reset", dut_word(), 32'd0);

        // Directed entry 3, A, 5, C.
        enter_four("entry", 16'h3A5C);
        chk_val("entry_seq", {16'd0, seq_out}, 32'h0000_3A5C);
        chk_val("entry_cnt", {29'd0, digit_count}, 32'd4);
        chk_val("entry_valid", {31'd0, seq_valid}, 32'd1);

        // Held full: key and clear activity must not disturb it.
        key_run("full_press", D + 8, 1'b1, 1'b0, 4'h7, 1'b0);
        key_run("full_clear", D + 8, 1'b0, 1'b1, 4'h7, 1'b0);
        key_run("full_both", D + 5, 1'b1, 1'b1, 4'h1, 1'b0);
        chk_val("full_hold", {16'd0, seq_out}, 32'h0000_3A5C);
        handshake("hs1");

        // Bounces that are too short, then one long hold.
        key_run("bounce1", 1, 1'b1, 1'b0, 4'h9, 1'b0);
        key_run("bounce2", 2, 1'b1, 1'b0, 4'h9, 1'b0);
        key_run("bounce3", D - 1, 1'b1, 1'b0, 4'h9, 1'b0);
        chk_val("bounce_cnt", {29'd0, digit_count}, 32'd0);
        key_run("hold50", 50, 1'b1, 1'b0, 4'h1, 1'b0);
        chk_val("hold_cnt", {29'd0, digit_count}, 32'd1);
        key_run("exact_d", D, 1'b1, 1'b0, 4'h2, 1'b1);
        chk_val("two_digits", {16'd0, seq_out}, 32'h0000_0012);
        key_run("clear", D + 4, 1'b0, 1'b1, 4'h0, 1'b0);
        chk_val("clear_cnt", {29'd0, digit_count}, 32'd0);
        key_run("d1", D + 3, 1'b1, 1'b0, 4'h6, 1'b1);
        key_run("press_clear", D + 4, 1'b1, 1'b1, 4'h8, 1'b0);
        chk_val("pc_cnt", {29'd0, digit_count}, 32'd0);

        // Reset in the middle of an entry and while a sequence is offered.
        for (int i = 0; i < 3; i++) key_run("pre_rst", D + 3, 1'b1, 1'b0, 4'(i + 1), 1'b0);
        pulse_reset("rst_mid");
        enter_four("full_rst", 16'hBEEF);
        pulse_reset("rst_full");
        enter_four("fresh", 16'h1234);
        chk_val("fresh_seq", {16'd0, seq_out}, 32'h0000_1234);
        handshake("hs2");

        // Randomized mix of operations.
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 9));
            s  = 16'($urandom);
            if (m_valid && op < 3) begin
                handshake("r_hs");
            end else if (op == 9) begin
                pulse_reset("r_rst");
            end else if (op <= 4) begin
                key_run("r_press", D + int'($urandom_range(0, 12)), 1'b1, 1'b0,
                        s[3:0], (m_cnt <= 2) ? s[4] : 1'b0);
            end else if (op == 5) begin
                key_run("r_bounce", int'($urandom_range(1, D - 1)), 1'b1, s[5],
                        s[3:0], 1'b0);
            end else if (op == 6) begin
                key_run("r_clear", D + int'($urandom_range(0, 8)), 1'b0, 1'b1,
                        s[3:0], (m_cnt <= 2) ? s[4] : 1'b0);
            end else begin
                key_run("r_both", D + int'($urandom_range(0, 8)), 1'b1, 1'b1,
                        s[3:0], 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total_r, bad_r);
        $finish;
    end

endmodule
